// File: rtl/dct_pkg.sv
// Shared definitions for the 8-point binDCT datapath and its transpose buffer.
package dct_pkg;

    localparam int DCT_N = 8;
    localparam int DEFAULT_COL_INTERVAL = 5;

    typedef logic signed [31:0] dct_sample_t;

    typedef enum logic {
        IDLE,
        DRAIN
    } tpose_state_t;

endpackage

// File: rtl/dct_tpose_bank.sv
// One 8x8 coefficient bank: whole-row writes, whole-column combinational reads.
module dct_tpose_bank
    import dct_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [2:0]              wr_row,
    input  logic signed [WIDTH-1:0] wr_data [0:DCT_N-1],
    input  logic [2:0]              rd_col,
    output logic signed [WIDTH-1:0] rd_data [0:DCT_N-1]
);

    logic signed [WIDTH-1:0] mem [0:DCT_N-1][0:DCT_N-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DCT_N; r++) begin
                for (int c = 0; c < DCT_N; c++) begin
                    mem[r][c] <= '0;
                end
            end
        end else if (we) begin
            for (int c = 0; c < DCT_N; c++) begin
                mem[wr_row][c] <= wr_data[c];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < DCT_N; r++) begin
            rd_data[r] = mem[r][rd_col];
        end
    end

endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose between the row-pass and column-pass DCT engines:
// rows fill one bank while the other drains column by column at a fixed cadence.
module dct_transpose_buffer
    import dct_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int COL_INTERVAL = DEFAULT_COL_INTERVAL
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic signed [WIDTH-1:0] row_in [0:DCT_N-1],
    output logic                    valid_out,
    output logic signed [WIDTH-1:0] col_out [0:DCT_N-1],
    output logic [2:0]              col_idx,
    output logic                    overflow,
    output logic                    busy
);

    localparam int GAP_W = (COL_INTERVAL > 1) ? $clog2(COL_INTERVAL) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(COL_INTERVAL - 1);

    tpose_state_t     state;
    logic [1:0]       full;
    logic             wr_bank;
    logic             rd_bank;
    logic [2:0]       wr_row;
    logic [2:0]       rd_col;
    logic [GAP_W-1:0] gap;

    logic             wr_accept;
    logic             emit;
    logic             we0;
    logic             we1;

    logic signed [WIDTH-1:0] bank0_data [0:DCT_N-1];
    logic signed [WIDTH-1:0] bank1_data [0:DCT_N-1];
    logic signed [WIDTH-1:0] rd_data    [0:DCT_N-1];

    // The full flag is sampled before any same-edge clear, so a row landing on a
    // bank as it is being freed is still dropped.
    assign wr_accept = valid_in && !full[wr_bank];
    assign we0       = wr_accept && (wr_bank == 1'b0);
    assign we1       = wr_accept && (wr_bank == 1'b1);
    assign busy      = (|wr_row) || (|full);

    always_comb begin
        emit = 1'b0;
        case (state)
            IDLE:    emit = full[rd_bank] && (gap == '0);
            DRAIN:   emit = (gap == '0);
            default: emit = 1'b0;
        endcase
    end

    always_comb begin
        for (int r = 0; r < DCT_N; r++) begin
            rd_data[r] = rd_bank ? bank1_data[r] : bank0_data[r];
        end
    end

    dct_tpose_bank #(.WIDTH(WIDTH)) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .we      (we0),
        .wr_row  (wr_row),
        .wr_data (row_in),
        .rd_col  (rd_col),
        .rd_data (bank0_data)
    );

    dct_tpose_bank #(.WIDTH(WIDTH)) u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .we      (we1),
        .wr_row  (wr_row),
        .wr_data (row_in),
        .rd_col  (rd_col),
        .rd_data (bank1_data)
    );

    // Gap keeps counting in IDLE too, so the next block's column 0 never comes
    // sooner than COL_INTERVAL after the previous block's column 7.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            full      <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_row    <= '0;
            rd_col    <= '0;
            gap       <= '0;
            valid_out <= 1'b0;
            col_idx   <= '0;
            overflow  <= 1'b0;
            for (int r = 0; r < DCT_N; r++) begin
                col_out[r] <= '0;
            end
        end else begin
            valid_out <= emit;

            if (wr_accept) begin
                wr_row <= wr_row + 3'd1;
                if (wr_row == 3'd7) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end
            end

            if (valid_in && full[wr_bank]) begin
                overflow <= 1'b1;
            end

            if (emit) begin
                for (int r = 0; r < DCT_N; r++) begin
                    col_out[r] <= rd_data[r];
                end
                col_idx <= rd_col;
                gap     <= GAP_LOAD;
                if (rd_col == 3'd7) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                    rd_col        <= '0;
                    state         <= IDLE;
                end else begin
                    rd_col <= rd_col + 3'd1;
                    state  <= DRAIN;
                end
            end else if (gap != '0) begin
                gap <= gap - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Randomized bench for dct_transpose_buffer against a timestamped block model,
// plus a directed check of a COL_INTERVAL=1 build.
module tb_dct_transpose_buffer;
    import dct_pkg::*;

    localparam int W  = 32;
    localparam int CI = 5;

    typedef struct {
        int           t;
        int           idx;
        logic [255:0] data;
    } exp_col_t;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic valid_in = 1'b0;
    logic signed [W-1:0] row_in [0:7];
    logic        valid_out;
    logic signed [W-1:0] col_out [0:7];
    logic [2:0]  col_idx;
    logic        overflow;
    logic        busy;

    logic valid_in1 = 1'b0;
    logic signed [W-1:0] row_in1 [0:7];
    logic        valid_out1;
    logic signed [W-1:0] col_out1 [0:7];
    logic [2:0]  col_idx1;
    logic        overflow1;
    logic        busy1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_col_t     exp_q [$];
    int           free_q [$];
    logic [255:0] part [0:7];
    int           part_rows = 0;
    int           last_col7 = -1000;
    logic         ovf_exp   = 1'b0;
    logic [255:0] hold_exp  = '0;
    logic [255:0] one_blk [0:7];

    always #5 clk = ~clk;

    dct_transpose_buffer #(.WIDTH(W), .COL_INTERVAL(CI)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .row_in    (row_in),
        .valid_out (valid_out),
        .col_out   (col_out),
        .col_idx   (col_idx),
        .overflow  (overflow),
        .busy      (busy)
    );

    dct_transpose_buffer #(.WIDTH(W), .COL_INTERVAL(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in1),
        .row_in    (row_in1),
        .valid_out (valid_out1),
        .col_out   (col_out1),
        .col_idx   (col_idx1),
        .overflow  (overflow1),
        .busy      (busy1)
    );

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h at cycle %0d", tag, got, want, cyc);
        end
    endtask

    function automatic logic [255:0] pack_col(input logic signed [W-1:0] v [0:7]);
        logic [255:0] p;
        p = '0;
        for (int r = 0; r < 8; r++) p[r*32 +: 32] = v[r];
        return p;
    endfunction

    function automatic logic [255:0] make_row(input int base);
        logic [255:0] p;
        for (int c = 0; c < 8; c++) p[c*32 +: 32] = base + c;
        return p;
    endfunction

    function automatic logic [255:0] const_row(input int v);
        logic [255:0] p;
        for (int c = 0; c < 8; c++) p[c*32 +: 32] = v;
        return p;
    endfunction

    function automatic logic [255:0] rand_row();
        logic [255:0] p;
        for (int c = 0; c < 8; c++) p[c*32 +: 32] = $urandom;
        return p;
    endfunction

    function automatic logic [255:0] transpose_col(input logic [255:0] rows [0:7], input int k);
        logic [255:0] p;
        for (int r = 0; r < 8; r++) p[r*32 +: 32] = rows[r][k*32 +: 32];
        return p;
    endfunction

    task automatic applyStimulus(input logic r, input logic v, input logic [255:0] rowbits);
        @(negedge clk);
        rst      = r;
        valid_in = v;
        for (int c = 0; c < 8; c++) row_in[c] = rowbits[c*32 +: 32];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0);
    endtask

    // Reference: a block is a list of 8 accepted rows; once complete its columns
    // are due at CI spacing, no earlier than one cycle after completion nor CI
    // after the previous block's last column, and it occupies a bank until then.
    always @(posedge clk) begin : model_blk
        int start;
        exp_col_t e;
        cyc = cyc + 1;
        while (free_q.size() > 0 && free_q[0] < cyc) free_q.delete(0);
        if (rst) begin
            exp_q.delete();
            free_q.delete();
            part_rows = 0;
            last_col7 = -1000;
            ovf_exp   = 1'b0;
        end else if (valid_in) begin
            if (free_q.size() >= 2) begin
                ovf_exp = 1'b1;
            end else begin
                part[part_rows] = pack_col(row_in);
                part_rows++;
                if (part_rows == 8) begin
                    start = (cyc + 1 > last_col7 + CI) ? cyc + 1 : last_col7 + CI;
                    for (int k = 0; k < 8; k++) begin
                        e.t    = start + k * CI;
                        e.idx  = k;
                        e.data = transpose_col(part, k);
                        exp_q.push_back(e);
                    end
                    last_col7 = start + 7 * CI;
                    free_q.push_back(last_col7);
                    part_rows = 0;
                end
            end
        end
    end

    always @(posedge clk) begin : check_blk
        exp_col_t e;
        logic exp_busy;
        #1;
        if (rst) hold_exp = '0;
        if (valid_out) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_valid", valid_out, 1'b0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("col_time", cyc, e.t);
                checkOutput("col_idx", col_idx, e.idx);
                checkOutput("col_data", pack_col(col_out), e.data);
                hold_exp = e.data;
            end
        end else begin
            if (exp_q.size() > 0 && exp_q[0].t <= cyc) begin
                checkOutput("col_missing", valid_out, 1'b1);
                exp_q.delete(0);
            end
            checkOutput("col_hold", pack_col(col_out), hold_exp);
        end
        exp_busy = (part_rows != 0);
        foreach (free_q[i]) if (free_q[i] > cyc) exp_busy = 1'b1;
        checkOutput("overflow", overflow, ovf_exp);
        checkOutput("busy", busy, exp_busy);
    end

    initial begin
        int n;
        logic [255:0] xrow;
        for (int c = 0; c < 8; c++) begin
            row_in[c]  = '0;
            row_in1[c] = '0;
        end

        $display("[TB] reset");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, '0);
        idle(2);

        $display("[TB] single block");
        for (int r = 0; r < 8; r++) begin
            applyStimulus(1'b0, 1'b1, make_row(16 * r));
            idle(4);
        end
        idle(40);

        $display("[TB] ping-pong");
        for (int b = 0; b < 3; b++) begin
            for (int r = 0; r < 8; r++) begin
                applyStimulus(1'b0, 1'b1, make_row(1000 * b + 16 * r));
                idle(4);
            end
        end
        idle(40);

        $display("[TB] overflow burst");
        for (int r = 0; r < 24; r++) applyStimulus(1'b0, 1'b1, rand_row());
        idle(90);

        $display("[TB] reset mid-block");
        for (int r = 0; r < 5; r++) applyStimulus(1'b0, 1'b1, rand_row());
        applyStimulus(1'b1, 1'b0, '0);
        idle(3);
        for (int r = 0; r < 8; r++) applyStimulus(1'b0, 1'b1, const_row(-(r + 1)));
        idle(40);

        $display("[TB] signed extremes");
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                xrow[c*32 +: 32] = (((c + r) % 2) == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
            end
            applyStimulus(1'b0, 1'b1, xrow);
        end
        idle(40);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0), rand_row());
        end
        idle(20);

        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            idle(1);
            n++;
        end
        if (exp_q.size() > 0) checkOutput("drain_timeout", exp_q.size(), 0);

        $display("[TB] COL_INTERVAL=1 build");
        checkOutput("ci1_busy_idle", busy1, 1'b0);
        for (int r = 0; r < 8; r++) one_blk[r] = rand_row();
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            valid_in1 = 1'b1;
            for (int c = 0; c < 8; c++) row_in1[c] = one_blk[r][c*32 +: 32];
        end
        @(negedge clk);
        valid_in1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            checkOutput("ci1_valid", valid_out1, 1'b1);
            checkOutput("ci1_idx", col_idx1, k);
            checkOutput("ci1_data", pack_col(col_out1), transpose_col(one_blk, k));
        end
        @(posedge clk);
        #1;
        checkOutput("ci1_valid_end", valid_out1, 1'b0);
        checkOutput("ci1_busy_end", busy1, 1'b0);
        checkOutput("ci1_overflow", overflow1, 1'b0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
